// File: rtl/alu_reg_sequencer.sv
// ---------------------------------------------------------------------------
// alu_reg_sequencer
//
// Multi-cycle control sequencer sitting between instruction fetch and the
// register-file/ALU datapath. One RV32I instruction is accepted per
// transaction over a valid/ready handshake and then walked through
// DECODE -> EXEC -> WB before the sequencer returns to IDLE.
//
// Supported instruction classes: R-type (0110011), I-type ALU (0010011)
// and conditional branches (1100011). Anything else, or an R-type with a
// funct7 other than 0000000/0100000, raises a one-cycle illegal pulse and
// the sequencer goes straight back to IDLE without a write.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   instr         instruction word, sampled only on an accepting edge
//   instr_valid   instr is valid
//   instr_ready   sequencer can accept an instruction
//   alu_result    ALU result from the datapath
//   alu_branch    ALU branch-condition output
//   rs1/rs2/rd    register addresses for the datapath
//   writeEnable   one-cycle register-file write strobe
//   reg_write     register-file write data (ALU result captured in EXEC)
//   ALU_source    0 = rs2 operand, 1 = immediate
//   opcode/funct3/funct7  instruction fields forwarded to the ALU
//   immediate     sign-extended immediate
//   done          one-cycle completion pulse
//   taken         branch outcome, valid while done is high
//   illegal       one-cycle unsupported-instruction pulse
//
// Every output is driven straight from a flop. The WB strobes (done,
// writeEnable, taken) are registered on the edge that ends WB, so they
// are visible in the cycle in which instr_ready has already returned.
// ---------------------------------------------------------------------------
module alu_reg_sequencer #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] alu_result,
    input  logic        alu_branch,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        writeEnable,
    output logic [31:0] reg_write,
    output logic        ALU_source,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [31:0] immediate,
    output logic        done,
    output logic        taken,
    output logic        illegal
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_B = 7'b1100011;

    // Value of the EXEC counter on the final EXEC edge.
    localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] instr_q, instr_d;
    logic        branch_q, branch_d;

    logic        instr_ready_q, instr_ready_d;
    logic [4:0]  rs1_q, rs1_d;
    logic [4:0]  rs2_q, rs2_d;
    logic [4:0]  rd_q, rd_d;
    logic        write_enable_q, write_enable_d;
    logic [31:0] reg_write_q, reg_write_d;
    logic        alu_source_q, alu_source_d;
    logic [6:0]  opcode_q, opcode_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [6:0]  funct7_q, funct7_d;
    logic [31:0] immediate_q, immediate_d;
    logic        done_q, done_d;
    logic        taken_q, taken_d;
    logic        illegal_q, illegal_d;

    // Field views of the captured instruction.
    logic [6:0]  cap_op;
    logic [2:0]  cap_f3;
    logic [6:0]  cap_f7;
    logic        is_r, is_i, is_b;
    logic        r_f7_ok, is_legal, is_write_class;

    always_comb begin
        cap_op         = instr_q[6:0];
        cap_f3         = instr_q[14:12];
        cap_f7         = instr_q[31:25];
        is_r           = (cap_op == OP_R);
        is_i           = (cap_op == OP_I);
        is_b           = (cap_op == OP_B);
        r_f7_ok        = (cap_f7 == 7'b0000000) || (cap_f7 == 7'b0100000);
        is_legal       = (is_r && r_f7_ok) || is_i || is_b;
        is_write_class = is_r || is_i;
    end

    // Next-state and next-output logic. Decoded fields hold their value
    // unless a legal instruction is being decoded; strobes default low.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        instr_d        = instr_q;
        branch_d       = branch_q;
        rs1_d          = rs1_q;
        rs2_d          = rs2_q;
        rd_d           = rd_q;
        reg_write_d    = reg_write_q;
        alu_source_d   = alu_source_q;
        opcode_d       = opcode_q;
        funct3_d       = funct3_q;
        funct7_d       = funct7_q;
        immediate_d    = immediate_q;
        write_enable_d = 1'b0;
        done_d         = 1'b0;
        taken_d        = 1'b0;
        illegal_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (instr_valid && instr_ready_q) begin
                    instr_d = instr;
                    state_d = DECODE;
                end
            end

            DECODE: begin
                if (is_legal) begin
                    rs1_d    = instr_q[19:15];
                    funct3_d = cap_f3;
                    opcode_d = cap_op;
                    if (is_r) begin
                        funct7_d     = cap_f7;
                        rs2_d        = instr_q[24:20];
                        rd_d         = instr_q[11:7];
                        immediate_d  = 32'd0;
                        alu_source_d = 1'b0;
                    end else if (is_i) begin
                        // Only the shift-immediates carry a meaningful funct7.
                        funct7_d     = ((cap_f3 == 3'b001) || (cap_f3 == 3'b101)) ? cap_f7 : 7'd0;
                        rs2_d        = 5'd0;
                        rd_d         = instr_q[11:7];
                        immediate_d  = {{20{instr_q[31]}}, instr_q[31:20]};
                        alu_source_d = 1'b1;
                    end else begin
                        funct7_d     = 7'd0;
                        rs2_d        = instr_q[24:20];
                        rd_d         = 5'd0;
                        immediate_d  = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                                        instr_q[30:25], instr_q[11:8], 1'b0};
                        alu_source_d = 1'b0;
                    end
                    cnt_d   = 4'd0;
                    state_d = EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = IDLE;
                end
            end

            EXEC: begin
                if (cnt_q == EXEC_LAST) begin
                    reg_write_d = alu_result;
                    branch_d    = alu_branch;
                    cnt_d       = 4'd0;
                    state_d     = WB;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            WB: begin
                done_d         = 1'b1;
                write_enable_d = is_write_class && (instr_q[11:7] != 5'd0);
                taken_d        = is_b && branch_q;
                state_d        = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Ready is registered from the next state so that a new accept can
        // happen on the edge right after the one that leaves WB.
        instr_ready_d = (state_d == IDLE);
    end

    // State and output registers; reset drops any in-flight instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= 4'd0;
            instr_q        <= 32'd0;
            branch_q       <= 1'b0;
            instr_ready_q  <= 1'b0;
            rs1_q          <= 5'd0;
            rs2_q          <= 5'd0;
            rd_q           <= 5'd0;
            write_enable_q <= 1'b0;
            reg_write_q    <= 32'd0;
            alu_source_q   <= 1'b0;
            opcode_q       <= 7'd0;
            funct3_q       <= 3'd0;
            funct7_q       <= 7'd0;
            immediate_q    <= 32'd0;
            done_q         <= 1'b0;
            taken_q        <= 1'b0;
            illegal_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            instr_q        <= instr_d;
            branch_q       <= branch_d;
            instr_ready_q  <= instr_ready_d;
            rs1_q          <= rs1_d;
            rs2_q          <= rs2_d;
            rd_q           <= rd_d;
            write_enable_q <= write_enable_d;
            reg_write_q    <= reg_write_d;
            alu_source_q   <= alu_source_d;
            opcode_q       <= opcode_d;
            funct3_q       <= funct3_d;
            funct7_q       <= funct7_d;
            immediate_q    <= immediate_d;
            done_q         <= done_d;
            taken_q        <= taken_d;
            illegal_q      <= illegal_d;
        end
    end

    always_comb begin
        instr_ready = instr_ready_q;
        rs1         = rs1_q;
        rs2         = rs2_q;
        rd          = rd_q;
        writeEnable = write_enable_q;
        reg_write   = reg_write_q;
        ALU_source  = alu_source_q;
        opcode      = opcode_q;
        funct3      = funct3_q;
        funct7      = funct7_q;
        immediate   = immediate_q;
        done        = done_q;
        taken       = taken_q;
        illegal     = illegal_q;
    end

endmodule

// File: tb/tb_alu_reg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_reg_sequencer
//
// Drives directed RV32I transactions followed by randomized traffic into
// alu_reg_sequencer. A transaction-level reference model predicts every
// output from the accept time of each instruction; a compare process checks
// all outputs shortly after every rising edge. Directed literal checks pin
// the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_alu_reg_sequencer;

    localparam int EXEC_CYCLES = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'd0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] alu_result = 32'd0;
    logic        alu_branch = 1'b0;
    logic [4:0]  rs1, rs2, rd;
    logic        writeEnable;
    logic [31:0] reg_write;
    logic        ALU_source;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] immediate;
    logic        done, taken, illegal;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    alu_reg_sequencer #(.EXEC_CYCLES(EXEC_CYCLES)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .alu_result(alu_result), .alu_branch(alu_branch),
        .rs1(rs1), .rs2(rs2), .rd(rd), .writeEnable(writeEnable), .reg_write(reg_write),
        .ALU_source(ALU_source), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .immediate(immediate), .done(done), .taken(taken), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Expected decode of one instruction, derived from the ISA field rules.
    typedef struct {
        bit          legal;
        bit          writes;
        bit          branch;
        logic [4:0]  rs1, rs2, rd;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [31:0] imm;
        bit          src;
    } dec_t;

    function automatic dec_t decodeRef(input logic [31:0] w);
        dec_t d;
        logic [12:0] boff;
        d = '{default: '0};
        d.op  = w[6:0];
        d.rs1 = w[19:15];
        d.f3  = w[14:12];
        if (w[6:0] == 7'h33) begin
            d.legal  = (w[31:25] == 7'h00) || (w[31:25] == 7'h20);
            d.writes = 1'b1;
            d.rs2    = w[24:20];
            d.rd     = w[11:7];
            d.f7     = w[31:25];
        end else if (w[6:0] == 7'h13) begin
            d.legal  = 1'b1;
            d.writes = 1'b1;
            d.rd     = w[11:7];
            d.imm    = 32'($signed(w[31:20]));
            d.src    = 1'b1;
            d.f7     = (w[14:12] == 3'd1 || w[14:12] == 3'd5) ? w[31:25] : 7'd0;
        end else if (w[6:0] == 7'h63) begin
            d.legal  = 1'b1;
            d.branch = 1'b1;
            d.rs2    = w[24:20];
            boff     = {w[31], w[7], w[30:25], w[11:8], 1'b0};
            d.imm    = 32'($signed(boff));
        end
        return d;
    endfunction

    // Reference model: remembers when the current instruction was accepted
    // and fires each effect at its fixed edge offset from that accept.
    logic        m_ready, m_we, m_done, m_taken, m_illegal, m_src;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [6:0]  m_op, m_f7;
    logic [2:0]  m_f3;
    logic [31:0] m_imm, m_regw;
    bit          m_active, m_br_cap;
    int          m_now, m_tacc;
    dec_t        m_dec;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            {m_ready, m_we, m_done, m_taken, m_illegal, m_src} = '0;
            {m_rs1, m_rs2, m_rd, m_op, m_f7, m_f3} = '0;
            m_imm = 0; m_regw = 0; m_active = 0; m_br_cap = 0; m_now = 0; m_tacc = 0;
        end else begin
            m_now++;
            m_we = 0; m_done = 0; m_taken = 0; m_illegal = 0;
            if (m_active) begin
                if (m_now - m_tacc == 1) begin
                    if (m_dec.legal) begin
                        m_rs1 = m_dec.rs1; m_rs2 = m_dec.rs2; m_rd = m_dec.rd;
                        m_op = m_dec.op; m_f3 = m_dec.f3; m_f7 = m_dec.f7;
                        m_imm = m_dec.imm; m_src = m_dec.src;
                    end else begin
                        m_illegal = 1;
                        m_active = 0;
                    end
                end
                if (m_active && m_now - m_tacc == EXEC_CYCLES + 1) begin
                    m_regw   = alu_result;
                    m_br_cap = alu_branch;
                end
                if (m_active && m_now - m_tacc == EXEC_CYCLES + 2) begin
                    m_done   = 1;
                    m_we     = m_dec.writes && (m_dec.rd != 0);
                    m_taken  = m_dec.branch && m_br_cap;
                    m_active = 0;
                end
            end else if (m_ready && instr_valid) begin
                m_active = 1;
                m_tacc   = m_now;
                m_dec    = decodeRef(instr);
            end
            m_ready = !m_active;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, sampled 1 time unit after the edge.
    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            checkOutput("instr_ready", 32'(instr_ready), 32'(m_ready));
            checkOutput("rs1", 32'(rs1), 32'(m_rs1));
            checkOutput("rs2", 32'(rs2), 32'(m_rs2));
            checkOutput("rd", 32'(rd), 32'(m_rd));
            checkOutput("writeEnable", 32'(writeEnable), 32'(m_we));
            checkOutput("reg_write", reg_write, m_regw);
            checkOutput("ALU_source", 32'(ALU_source), 32'(m_src));
            checkOutput("opcode", 32'(opcode), 32'(m_op));
            checkOutput("funct3", 32'(funct3), 32'(m_f3));
            checkOutput("funct7", 32'(funct7), 32'(m_f7));
            checkOutput("immediate", immediate, m_imm);
            checkOutput("done", 32'(done), 32'(m_done));
            checkOutput("taken", 32'(taken), 32'(m_taken));
            checkOutput("illegal", 32'(illegal), 32'(m_illegal));
        end
    end

    task automatic applyStimulus(input logic [31:0] w, input logic v,
                                 input logic [31:0] res, input logic br);
        instr       = w;
        instr_valid = v;
        alu_result  = res;
        alu_branch  = br;
    endtask

    // Waits (bounded) for instr_ready at a falling edge.
    task automatic waitReady();
        int n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (instr_ready !== 1'b1) checkOutput("ready_timeout", 32'(instr_ready), 32'd1);
    endtask

    // Accepts one instruction and returns one falling edge after decode.
    task automatic startTxn(input logic [31:0] w, input logic [31:0] res, input logic br);
        waitReady();
        applyStimulus(w, 1'b1, res, br);
        @(negedge clk);
        applyStimulus(32'hDEADBEEF, 1'b0, res, br);
        @(negedge clk);
    endtask

    function automatic logic [31:0] randInstr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 5))
            0: begin w[6:0] = 7'h33; w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
            1: w[6:0] = 7'h33;
            2, 3: w[6:0] = 7'h13;
            4: w[6:0] = 7'h63;
            default: ;
        endcase
        if ($urandom_range(0, 3) == 0) w[11:7] = 5'd0;
        return w;
    endfunction

    initial begin
        cmp_en = 1'b1;
        applyStimulus(32'd0, 1'b0, 32'd0, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", 32'(instr_ready), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_we", 32'(writeEnable), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_rst", 32'(instr_ready), 32'd1);

        // ADD x3,x1,x2
        startTxn(32'h002081B3, 32'h00000005, 1'b0);
        checkOutput("add_rs1", 32'(rs1), 32'd1);
        checkOutput("add_rs2", 32'(rs2), 32'd2);
        checkOutput("add_rd", 32'(rd), 32'd3);
        checkOutput("add_opcode", 32'(opcode), 32'h33);
        checkOutput("add_src", 32'(ALU_source), 32'd0);
        @(negedge clk);
        checkOutput("add_done_early", 32'(done), 32'd0);
        @(negedge clk);
        checkOutput("add_we", 32'(writeEnable), 32'd1);
        checkOutput("add_regw", reg_write, 32'd5);
        checkOutput("add_done", 32'(done), 32'd1);

        // ADDI x1,x0,-1
        startTxn(32'hFFF00093, 32'h12345678, 1'b0);
        checkOutput("addi_imm", immediate, 32'hFFFFFFFF);
        checkOutput("addi_src", 32'(ALU_source), 32'd1);
        checkOutput("addi_f7", 32'(funct7), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("addi_we", 32'(writeEnable), 32'd1);
        checkOutput("addi_regw", reg_write, 32'h12345678);

        // BEQ x1,x2,+8
        startTxn(32'h00208463, 32'h0, 1'b1);
        checkOutput("beq_imm", immediate, 32'd8);
        checkOutput("beq_rd", 32'(rd), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("beq_done", 32'(done), 32'd1);
        checkOutput("beq_taken", 32'(taken), 32'd1);
        checkOutput("beq_we", 32'(writeEnable), 32'd0);

        // Unsupported opcode
        startTxn(32'h00000000, 32'h0, 1'b0);
        checkOutput("ill_pulse", 32'(illegal), 32'd1);
        checkOutput("ill_done", 32'(done), 32'd0);
        @(negedge clk);
        checkOutput("ill_clear", 32'(illegal), 32'd0);
        checkOutput("ill_ready", 32'(instr_ready), 32'd1);

        // ADD to x0
        startTxn(32'h00208033, 32'h00000077, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("x0_done", 32'(done), 32'd1);
        checkOutput("x0_we", 32'(writeEnable), 32'd0);

        // Reset during EXEC with the next instruction already held valid
        startTxn(32'h002081B3, 32'h00000009, 1'b0);
        applyStimulus(32'hFFF00093, 1'b1, 32'h00000042, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("rstx_rs1", 32'(rs1), 32'd0);
        checkOutput("rstx_ready", 32'(instr_ready), 32'd0);
        @(negedge clk);
        checkOutput("rstx_we", 32'(writeEnable), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstx_ready_back", 32'(instr_ready), 32'd1);
        @(negedge clk);
        checkOutput("rstx_accepted", 32'(instr_ready), 32'd0);
        instr_valid = 1'b0;
        @(negedge clk);
        checkOutput("rstx_rd", 32'(rd), 32'd1);
        repeat (2) @(negedge clk);
        checkOutput("rstx_done", 32'(done), 32'd1);
        checkOutput("rstx_regw", reg_write, 32'h00000042);

        // Randomized traffic, including occasional reset pulses
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                rst = 1'b0;
            end
            applyStimulus(randInstr(), ($urandom_range(0, 9) < 6), $urandom, 1'($urandom));
        end
        instr_valid = 1'b0;
        repeat (10) @(negedge clk);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
